// File: rtl/emu_replay_pkg.sv
// Shared types for the checkpoint replay sequencer.
// State encoding used by the control FSM.
package emu_replay_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE     = 3'd0,
    LOAD_FF  = 3'd1,
    LOAD_MEM = 3'd2,
    SETTLE   = 3'd3,
    RUN      = 3'd4,
    FIN      = 3'd5
  } state_e;

endpackage

// File: rtl/emu_replay_wcnt.sv
// Checkpoint word counter with a run-time terminal value.
// tc flags that the current count equals the terminal value.
module emu_replay_wcnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/emu_replay_ctrl.sv
// Checkpoint replay sequencer: scan-load FF then memory chains,
// then run the emulated design clock for a fixed cycle count.
module emu_replay_ctrl
  import emu_replay_pkg::*;
#(
  parameter int LOAD_WIDTH = 64,
  parameter int FF_WORDS   = 16,
  parameter int MEM_WORDS  = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  start_cycle,
  input  logic [CNT_WIDTH-1:0]  run_cycle,
  input  logic                  ckpt_valid,
  input  logic [LOAD_WIDTH-1:0] ckpt_data,
  output logic                  ckpt_ready,
  output logic                  ff_scan_en,
  output logic                  mem_scan_en,
  output logic [LOAD_WIDTH-1:0] scan_in,
  output logic                  emu_clk_en,
  output logic [CNT_WIDTH-1:0]  cycle,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam int WMAX = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
  localparam int WC_W = (WMAX > 1) ? $clog2(WMAX) : 1;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] end_q, end_d;
  logic [CNT_WIDTH-1:0] cycle_inc;
  logic                 clk_en_q, clk_en_d;
  logic                 aborted_q, aborted_d;
  logic                 kill;
  logic                 xfer;
  logic                 wc_clr;
  logic                 wc_tc;
  logic [WC_W-1:0]      wc_term;

  // abort only acts on an operation in flight
  assign kill      = abort && (state_q != IDLE);
  assign cycle_inc = cycle_q + 1'b1;
  assign xfer      = ckpt_valid && ckpt_ready;
  assign wc_clr    = (state_q == IDLE) || (xfer && wc_tc);
  assign wc_term   = (state_q == LOAD_MEM) ? WC_W'(MEM_WORDS - 1)
                                           : WC_W'(FF_WORDS - 1);

  emu_replay_wcnt #(
    .W (WC_W)
  ) u_wcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wc_clr),
    .inc   (xfer),
    .term  (wc_term),
    .tc    (wc_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cycle_q   <= '0;
      end_q     <= '0;
      clk_en_q  <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      end_q     <= end_d;
      clk_en_q  <= clk_en_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    end_d   = end_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD_FF;
          cycle_d = start_cycle;
          end_d   = start_cycle + run_cycle;
        end
      end
      LOAD_FF:  if (xfer && wc_tc) state_d = LOAD_MEM;
      LOAD_MEM: if (xfer && wc_tc) state_d = SETTLE;
      SETTLE:   state_d = (cycle_q == end_q) ? FIN : RUN;
      RUN: begin
        cycle_d = cycle_inc;
        if (cycle_inc == end_q) state_d = FIN;
      end
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      cycle_d = cycle_q;
      end_d   = end_q;
    end
    clk_en_d  = (state_d == RUN);
    aborted_d = kill;
  end

  always_comb begin
    ckpt_ready  = 1'b0;
    ff_scan_en  = 1'b0;
    mem_scan_en = 1'b0;
    if (!abort) begin
      ckpt_ready  = (state_q == LOAD_FF) || (state_q == LOAD_MEM);
      ff_scan_en  = (state_q == LOAD_FF) && ckpt_valid;
      mem_scan_en = (state_q == LOAD_MEM) && ckpt_valid;
    end
    emu_clk_en = clk_en_q && !abort;
    busy       = (state_q != IDLE);
    done       = (state_q == FIN);
    aborted    = aborted_q;
    cycle      = cycle_q;
    scan_in    = ckpt_data;
  end

endmodule

// File: tb/tb_emu_replay_ctrl.sv
// Scoreboard bench for emu_replay_ctrl with a 2-word FF chain
// and a 3-word memory chain.
module tb_emu_replay_ctrl;

  localparam int LW = 64;
  localparam int FW = 2;
  localparam int MW = 3;
  localparam int CW = 64;

  localparam int K_FF   = 1;
  localparam int K_MEM  = 2;
  localparam int K_DONE = 3;
  localparam int K_ABT  = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] start_cycle;
  logic [CW-1:0] run_cycle;
  logic          ckpt_valid;
  logic [LW-1:0] ckpt_data;
  logic          ckpt_ready;
  logic          ff_scan_en;
  logic          mem_scan_en;
  logic [LW-1:0] scan_in;
  logic          emu_clk_en;
  logic [CW-1:0] cycle;
  logic          busy;
  logic          done;
  logic          aborted;

  emu_replay_ctrl #(
    .LOAD_WIDTH (LW),
    .FF_WORDS   (FW),
    .MEM_WORDS  (MW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .start_cycle (start_cycle),
    .run_cycle   (run_cycle),
    .ckpt_valid  (ckpt_valid),
    .ckpt_data   (ckpt_data),
    .ckpt_ready  (ckpt_ready),
    .ff_scan_en  (ff_scan_en),
    .mem_scan_en (mem_scan_en),
    .scan_in     (scan_in),
    .emu_clk_en  (emu_clk_en),
    .cycle       (cycle),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] val;
    int          n;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] src_q[$];
  int          total  = 0;
  int          bad    = 0;
  int          en_cnt = 0;
  int          tick   = 0;
  bit          gap    = 1'b0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic take_evt(int kind, logic [63:0] val);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_evt", 64'(kind), 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check("evt_kind", 64'(kind), 64'(e.kind));
    check("evt_val", val, e.val);
    if (kind == K_DONE)
      check("clk_en_cycles", 64'(en_cnt), 64'(e.n));
    if (kind >= K_DONE)
      en_cnt = 0;
  endtask

  // Source: presents queued words, valid pattern 1,0,0 when gap is set
  initial begin
    logic [63:0] tmp;
    ckpt_valid = 1'b0;
    ckpt_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ckpt_valid && ckpt_ready && !abort && src_q.size() > 0)
        tmp = src_q.pop_front();
      @(posedge clk);
      #2;
      tick++;
      ckpt_valid = (src_q.size() > 0) && (!gap || (tick % 3 == 0));
      ckpt_data  = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0;
    end else begin
      if (emu_clk_en)
        en_cnt++;
      if (ff_scan_en || mem_scan_en) begin
        check("scan_excl", 64'(ff_scan_en && mem_scan_en), 64'd0);
        take_evt(ff_scan_en ? K_FF : K_MEM, scan_in);
      end
      if (done)
        take_evt(K_DONE, cycle);
      if (aborted)
        take_evt(K_ABT, 64'd0);
    end
  end

  task automatic push_words(int n, logic [63:0] base);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = base + 64'(i) * 64'h0101_0101_0101_0101;
      src_q.push_back(w);
      exp_q.push_back('{(i < FW) ? K_FF : K_MEM, w, 0});
    end
  endtask

  task automatic push_done(logic [63:0] fin, int n);
    exp_q.push_back('{K_DONE, fin, n});
  endtask

  task automatic do_start(logic [63:0] sc, logic [63:0] rc);
    @(posedge clk);
    #1;
    start       = 1'b1;
    start_cycle = sc;
    run_cycle   = rc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy)
        ok = 1'b1;
    end
    if (!ok)
      check(nm, 64'd0, 64'd1);
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] c0;
    bit          seen;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    start_cycle = '0;
    run_cycle   = '0;
    #23;
    check("rst_outs",
          64'({ckpt_ready, ff_scan_en, mem_scan_en, emu_clk_en, busy, done, aborted}),
          64'd0);
    check("rst_cycle", cycle, 64'd0);
    check("rst_scan_in", scan_in, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic load and run
    push_words(5, 64'hA000_0000_0000_0010);
    push_done(64'd105, 5);
    do_start(64'd100, 64'd5);
    wait_idle("t1_timeout");

    // Valid gaps
    gap = 1'b1;
    push_words(5, 64'hB000_0000_0000_0020);
    push_done(64'd13, 3);
    do_start(64'd10, 64'd3);
    wait_idle("t2_timeout");
    gap = 1'b0;

    // Zero-length run
    push_words(5, 64'hC000_0000_0000_0030);
    push_done(64'd7, 0);
    do_start(64'd7, 64'd0);
    wait_idle("t3_timeout");

    // Counter wrap
    push_words(5, 64'hD000_0000_0000_0040);
    push_done(64'd2, 4);
    do_start(64'hFFFF_FFFF_FFFF_FFFE, 64'd4);
    wait_idle("t4_timeout");

    // Abort in LOAD_MEM after one memory word
    push_words(3, 64'hE000_0000_0000_0050);
    exp_q.push_back('{K_ABT, 64'd0, 0});
    do_start(64'd200, 64'd10);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (src_q.size() == 0)
        seen = 1'b1;
    end
    check("t5_load_reached", 64'(seen), 64'd1);
    src_q.push_back(64'hDEAD_BEEF_0000_0001);
    abort = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    check("t5_word_kept", 64'(src_q.size()), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_cycle_frozen", cycle, 64'd200);
    src_q.delete();
    wait_idle("t5_abort_timeout");
    push_words(5, 64'hF000_0000_0000_0060);
    push_done(64'd210, 10);
    do_start(64'd200, 64'd10);
    wait_idle("t5_reload_timeout");

    // Start while busy, then reset mid-RUN
    push_words(5, 64'h1000_0000_0000_0070);
    push_done(64'd70, 20);
    do_start(64'd50, 64'd20);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (emu_clk_en)
        seen = 1'b1;
    end
    check("t6_run_reached", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    c0 = cycle;
    do_start(64'd555, 64'd1);
    @(negedge clk);
    check("t6_start_ignored", cycle, c0 + 64'd2);
    check("t6_still_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs",
          64'({ckpt_ready, ff_scan_en, mem_scan_en, emu_clk_en, busy, done, aborted}),
          64'd0);
    check("t6_rst_cycle", cycle, 64'd0);
    exp_q.delete();
    src_q.delete();
    #10;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Recovery after reset
    push_words(5, 64'h2000_0000_0000_0080);
    push_done(64'd3, 3);
    do_start(64'd0, 64'd3);
    wait_idle("t7_timeout");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
